// File: rtl/position_update_node.sv
// Spatial-decomposition node: streams particles out of the read bank, advances
// positions by v>>>DT_SHIFT, keeps in-cell particles and forwards emigrants on the ring.
module position_update_node #(
  parameter int DW         = 32,
  parameter int CB         = 1,
  parameter int AW         = 10,
  parameter int DT_SHIFT   = 4,
  parameter int CELL_ID    = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW:0]     count,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [3*DW-1:0] rd_pos,
  input  logic [3*DW-1:0] rd_vel,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [3*DW-1:0] wr_pos,
  output logic [3*DW-1:0] wr_vel,
  input  logic            ring_in_valid,
  output logic            ring_in_ready,
  input  logic [3*DW-1:0] ring_in_pos,
  input  logic [3*DW-1:0] ring_in_vel,
  input  logic [3*CB-1:0] ring_in_dst,
  output logic            ring_out_valid,
  input  logic            ring_out_ready,
  output logic [3*DW-1:0] ring_out_pos,
  output logic [3*DW-1:0] ring_out_vel,
  output logic [3*CB-1:0] ring_out_dst,
  input  logic            ring_quiet,
  output logic            idle,
  output logic            done,
  output logic [AW:0]     wr_count,
  output logic            overflow
);

  localparam int CW   = 3 * CB;
  localparam int PW   = 3 * DW;
  localparam int FW   = 2 * PW + CW;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0]   MY_CELL   = CW'(CELL_ID);
  localparam logic [CNTW-1:0] FIFO_CAP  = CNTW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] FREE_MIN  = CNTW'(4);
  localparam logic [PTRW-1:0] PTR_LAST  = PTRW'(FIFO_DEPTH - 1);
  localparam logic [AW:0]     WR_LIMIT  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic [AW:0]     rd_ptr;
  logic            rd_pend;
  logic            hold_valid;
  logic [PW-1:0]   hold_pos, hold_vel;
  logic            s2_valid;
  logic [PW-1:0]   s2_pos, s2_vel;
  logic [CW-1:0]   s2_dst;
  logic [AW-1:0]   wr_ptr;

  logic [FW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTRW-1:0] fifo_head, fifo_tail;
  logic [CNTW-1:0] fifo_cnt;

  logic            in_valid;
  logic [PW-1:0]   in_pos, in_vel, nx_pos;
  logic [CW-1:0]   nx_dst;
  logic signed [DW-1:0] vsh;
  logic            start_ok, scan_done, scanning, accepting;
  logic            fifo_full, fifo_pop, fifo_push, local_push;
  logic            s2_keep, s2_stall;
  logic            ring_local, ring_acc, ring_fwd, ring_keep;
  logic            wr_req;
  logic [FW-1:0]   push_data, head_data;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = SCAN;
      SCAN:  if (scan_done) state_nx = DRAIN;
      DRAIN: if (idle && ring_quiet) state_nx = DONE;
      DONE:  if (start) state_nx = SCAN;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    scanning  = (state == SCAN);
    accepting = (state != IDLE);
    done      = (state == DONE);
    idle      = (state == DRAIN) && (fifo_cnt == '0) && !s2_valid;
  end

  assign start_ok  = start && (state == IDLE || state == DONE);
  assign scan_done = !(rd_ptr < count) && !rd_pend && !hold_valid && !s2_valid;

  // ---------------- datapath ----------------
  // Read data that cannot enter a stalled S2 is parked in the hold register.
  assign in_valid = rd_pend || hold_valid;
  assign in_pos   = hold_valid ? hold_pos : rd_pos;
  assign in_vel   = hold_valid ? hold_vel : rd_vel;

  always_comb begin
    nx_pos = '0;
    nx_dst = '0;
    vsh    = '0;
    for (int unsigned a = 0; a < 3; a++) begin
      vsh = $signed(in_vel[a*DW +: DW]) >>> DT_SHIFT;
      nx_pos[a*DW +: DW] = in_pos[a*DW +: DW] + $unsigned(vsh);
      nx_dst[a*CB +: CB] = nx_pos[a*DW + DW - 1 -: CB];
    end
  end

  assign s2_keep    = s2_valid && (s2_dst == MY_CELL);
  assign fifo_full  = (fifo_cnt == FIFO_CAP);
  assign fifo_pop   = ring_out_valid && ring_out_ready;

  assign ring_local    = (ring_in_dst == MY_CELL);
  assign ring_in_ready = accepting && !s2_keep && (ring_local || !fifo_full);
  assign ring_acc      = ring_in_valid && ring_in_ready;
  assign ring_fwd      = ring_acc && !ring_local;
  assign ring_keep     = ring_acc && ring_local;

  // Ring traffic owns the push port; a local emigrant waits in S2 behind it.
  assign local_push = s2_valid && !s2_keep && !ring_fwd && (!fifo_full || fifo_pop);
  assign s2_stall   = s2_valid && !s2_keep && !local_push;
  assign fifo_push  = ring_fwd || local_push;
  assign push_data  = ring_fwd ? {ring_in_dst, ring_in_vel, ring_in_pos}
                               : {s2_dst, s2_vel, s2_pos};

  assign rd_en   = scanning && (rd_ptr < count) && ((FIFO_CAP - fifo_cnt) >= FREE_MIN)
                   && !hold_valid && !s2_stall;
  assign rd_addr = rd_ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      rd_pend    <= 1'b0;
      hold_valid <= 1'b0;
      hold_pos   <= '0;
      hold_vel   <= '0;
      s2_valid   <= 1'b0;
      s2_pos     <= '0;
      s2_vel     <= '0;
      s2_dst     <= '0;
    end else begin
      rd_pend <= rd_en;
      if (start_ok)   rd_ptr <= '0;
      else if (rd_en) rd_ptr <= rd_ptr + 1'b1;

      if (!s2_stall) begin
        s2_valid   <= in_valid;
        hold_valid <= 1'b0;
        if (in_valid) begin
          s2_pos <= nx_pos;
          s2_vel <= in_vel;
          s2_dst <= nx_dst;
        end
      end else if (in_valid) begin
        hold_valid <= 1'b1;
        if (!hold_valid) begin
          hold_pos <= rd_pos;
          hold_vel <= rd_vel;
        end
      end
    end
  end

  // ---------------- write port ----------------
  assign wr_req = s2_keep || ring_keep;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_pos   <= '0;
      wr_vel   <= '0;
      wr_ptr   <= '0;
      wr_count <= '0;
      overflow <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start_ok) begin
        wr_ptr   <= '0;
        wr_count <= '0;
        overflow <= 1'b0;
      end else if (wr_req) begin
        if (wr_count == WR_LIMIT) begin
          overflow <= 1'b1;
        end else begin
          wr_en    <= 1'b1;
          wr_addr  <= wr_ptr;
          wr_pos   <= s2_keep ? s2_pos : ring_in_pos;
          wr_vel   <= s2_keep ? s2_vel : ring_in_vel;
          wr_ptr   <= wr_ptr + 1'b1;
          wr_count <= wr_count + 1'b1;
        end
      end
    end
  end

  // ---------------- ring output FIFO ----------------
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_tail] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_head <= '0;
      fifo_tail <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (fifo_push) fifo_tail <= (fifo_tail == PTR_LAST) ? '0 : fifo_tail + 1'b1;
      if (fifo_pop)  fifo_head <= (fifo_head == PTR_LAST) ? '0 : fifo_head + 1'b1;
      if (fifo_push && !fifo_pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (fifo_pop && !fifo_push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  assign head_data      = fifo_mem[fifo_head];
  assign ring_out_valid = (fifo_cnt != '0);
  assign ring_out_pos   = head_data[PW-1:0];
  assign ring_out_vel   = head_data[2*PW-1:PW];
  assign ring_out_dst   = head_data[FW-1:2*PW];

endmodule

// File: doc/position_update_node.md
POSITION_UPDATE_NODE -- requirements
Module: position_update_node

Interface
REQ-001 SHALL have parameter DW, 32, per-axis position/velocity width.
REQ-002 SHALL have parameter CB, 1, cell-index bits per axis; N_CELL = 2^(3*CB).
REQ-003 SHALL have parameter AW, 10, cache address width.
REQ-004 SHALL have parameter DT_SHIFT, 4, timestep as an arithmetic right shift of velocity.
REQ-005 SHALL have parameter CELL_ID, 0, this node's 3*CB-bit cell index.
REQ-006 SHALL have parameter FIFO_DEPTH, 8, ring output FIFO depth; at least 4.
REQ-007 SHALL have ports clk in 1, the single clock; reset in 1, synchronous and active-high.
REQ-008 SHALL have ports start in 1, begin pass; count in AW+1, valid particles in read bank.
REQ-009 SHALL have ports rd_en out 1; rd_addr out AW; rd_pos in 3*DW; rd_vel in 3*DW; read data is valid the cycle after rd_en.
REQ-010 SHALL have ports wr_en out 1; wr_addr out AW; wr_pos out 3*DW; wr_vel out 3*DW, all registered.
REQ-011 SHALL have ports ring_in_valid in 1; ring_in_ready out 1; ring_in_pos in 3*DW; ring_in_vel in 3*DW; ring_in_dst in 3*CB.
REQ-012 SHALL have ports ring_out_valid out 1; ring_out_ready in 1; ring_out_pos out 3*DW; ring_out_vel out 3*DW; ring_out_dst out 3*CB.
REQ-013 SHALL have ports ring_quiet in 1, AND of all nodes' idle; idle out 1; done out 1; wr_count out AW+1; overflow out 1.
REQ-014 SHALL pack axes as {z,y,x}, x in bits [DW-1:0].

Function
REQ-015 SHALL implement states IDLE, SCAN, DRAIN, DONE; start in IDLE or DONE -> SCAN with rd_ptr=0, wr_ptr=0, wr_count=0, overflow=0; start ignored elsewhere.
REQ-016 SHALL, in SCAN, assert rd_en with rd_addr=rd_ptr and increment rd_ptr only when rd_ptr<count and FIFO free slots >= 4.
REQ-017 SHALL compute per axis p' = p + (v >>> DT_SHIFT), v two's complement, sum modulo 2^DW (periodic wrap).
REQ-018 SHALL compute dst = {p'z[DW-1-:CB], p'y[DW-1-:CB], p'x[DW-1-:CB]}.
REQ-019 SHALL register the result in compute stage S2 the cycle after read data; kept particle (dst==CELL_ID) read at cycle t appears on wr_en at t+3.
REQ-020 SHALL enqueue an emigrant (dst!=CELL_ID) with p', unchanged v and dst into the FIFO; no write issued.
REQ-021 SHALL drive ring_out_* from the FIFO head; ring_out_valid = FIFO non-empty; pop on valid&&ready.
REQ-022 SHALL assert ring_in_ready in SCAN/DRAIN/DONE when no S2 keep this cycle and, for ring_in_dst!=CELL_ID, FIFO free >= 1.
REQ-023 SHALL write an accepted ring packet with dst==CELL_ID to wr_addr=wr_ptr next cycle; else push it to the FIFO unchanged.
REQ-024 SHALL give ring forwarding priority over local emigrants on the FIFO push port; simultaneous push stalls S2 one cycle and holds S2 and the read pipeline.
REQ-025 SHALL increment wr_ptr and wr_count per write; at wr_count=2^AW further writes dropped and overflow set sticky.
REQ-026 SHALL enter DRAIN when rd_ptr=count and no read/S2 in flight; count=0 enters DRAIN one cycle after start.
REQ-027 SHALL assert idle in DRAIN when FIFO empty and S2 empty; DRAIN -> DONE when idle and ring_quiet.
REQ-028 SHALL hold done high in DONE until next start; wr_count stable in DONE.
REQ-029 SHALL handle a FIFO full + pop same cycle as push allowed.

Reset
REQ-030 SHALL on reset enter IDLE, flush FIFO and S2, and drive rd_en, wr_en, ring_out_valid, ring_in_ready, idle, done, overflow low and wr_count, rd_ptr, wr_ptr zero, including mid-SCAN.

Verification
REQ-031 Keep: count=1, pos x=y=z=0x1000, vel x=0x100 -> wr_pos x=0x1010, wr_addr 0, wr_en 3 cycles after rd_en, wr_count=1.
REQ-032 Emigrate: x=0x7FFFFFF8, vel x=0x100 -> ring_out_pos x=0x80000008, dst=3'b001, no wr_en; negative v x=0x10, vel 0xFFFFFE00 -> x'=0xFFFFFFF0, dst=3'b001.
REQ-033 Wrap: x=0xFFFFFFF8, vel 0x100 -> x'=0x00000008, kept, dst=0.
REQ-034 Collision: ring_in dst=0 valid in cycle of S2 keep -> ring_in_ready 0, accepted next cycle, written at wr_addr 1 after local at 0.
REQ-035 Backpressure: count=16, all emigrate, ring_out_ready=0 -> rd_en stops after FIFO free<4; release -> 16 packets out, none lost, then DONE with ring_quiet.
REQ-036 Reset asserted mid-SCAN -> next cycle all outputs at reset values; new start runs cleanly.
